// File: rtl/data_mem.sv
// RV32I data memory: one load/store at a time, byte/half/word access with
// sign/zero extension, error reporting and a configurable number of wait states.
module data_mem #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_addr,
  input  logic        mem_read_valid,
  input  logic        mem_write_valid,
  input  logic [2:0]  mem_funct3,
  input  logic [31:0] mem_write_data,
  output logic [31:0] mem_read_data,
  output logic        mem_ready,
  output logic        mem_error,
  output logic        mem_busy
);

  localparam int unsigned IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] SPAN      = 33'(DEPTH_WORDS) * 33'd4;
  localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [2:0]  f3_q;
  logic        wr_q;
  logic [3:0]  cnt;
  logic [31:0] mem [DEPTH_WORDS];

  logic             accept_c;
  logic             resp_go_c;
  logic [31:0]      a_c;
  logic [2:0]       f3_c;
  logic             wr_c;
  logic [31:0]      off_c;
  logic [1:0]       lane_c;
  logic [IDX_W-1:0] idx_c;
  logic             in_range_c;
  logic             legal_c;
  logic             err_c;
  logic [31:0]      word_c;
  logic [7:0]       byte_c;
  logic [15:0]      half_c;
  logic [31:0]      load_c;
  logic [3:0]       be_c;
  logic [31:0]      wlane_c;

  // Operands come straight from the port in IDLE (zero-wait path), else from the latch.
  always_comb begin
    accept_c   = (state == S_IDLE) && (mem_read_valid || mem_write_valid);
    resp_go_c  = (accept_c && (WAIT_STATES == 0)) || ((state == S_WAIT) && (cnt == 4'd0));
    a_c        = (state == S_IDLE) ? mem_addr : addr_q;
    f3_c       = (state == S_IDLE) ? mem_funct3 : f3_q;
    wr_c       = (state == S_IDLE) ? mem_write_valid : wr_q;
    off_c      = a_c - BASE_ADDR;
    lane_c     = a_c[1:0];
    idx_c      = off_c[IDX_W+1:2];
    in_range_c = (a_c >= BASE_ADDR) && ({1'b0, off_c} < SPAN);
    case (f3_c)
      3'd0:    legal_c = 1'b1;
      3'd4:    legal_c = !wr_c;
      3'd1:    legal_c = !lane_c[0];
      3'd5:    legal_c = !wr_c && !lane_c[0];
      3'd2:    legal_c = (lane_c == 2'd0);
      default: legal_c = 1'b0;
    endcase
    err_c  = !in_range_c || !legal_c;
    word_c = mem[idx_c];
    byte_c = 8'(word_c >> {lane_c, 3'b000});
    half_c = lane_c[1] ? word_c[31:16] : word_c[15:0];
    case (f3_c)
      3'd0:    load_c = {{24{byte_c[7]}}, byte_c};
      3'd4:    load_c = {24'd0, byte_c};
      3'd1:    load_c = {{16{half_c[15]}}, half_c};
      3'd5:    load_c = {16'd0, half_c};
      3'd2:    load_c = word_c;
      default: load_c = 32'd0;
    endcase
    case (f3_c)
      3'd0:    be_c = 4'(4'b0001 << lane_c);
      3'd1:    be_c = lane_c[1] ? 4'b1100 : 4'b0011;
      default: be_c = 4'b1111;
    endcase
    case (f3_c)
      3'd0:    wlane_c = {4{wdata_q[7:0]}};
      3'd1:    wlane_c = {2{wdata_q[15:0]}};
      default: wlane_c = wdata_q;
    endcase
  end

  // Access sequencer; the load result is captured on the edge entering RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      mem_ready     <= 1'b0;
      mem_error     <= 1'b0;
      mem_busy      <= 1'b0;
      mem_read_data <= 32'd0;
      cnt           <= 4'd0;
      addr_q        <= 32'd0;
      wdata_q       <= 32'd0;
      f3_q          <= 3'd0;
      wr_q          <= 1'b0;
    end else begin
      mem_ready <= 1'b0;
      mem_error <= 1'b0;
      case (state)
        S_IDLE: if (accept_c) begin
          addr_q   <= mem_addr;
          wdata_q  <= mem_write_data;
          f3_q     <= mem_funct3;
          wr_q     <= mem_write_valid;
          mem_busy <= 1'b1;
          if (WAIT_STATES > 0) begin
            state <= S_WAIT;
            cnt   <= WAIT_LOAD;
          end else begin
            state <= S_RESP;
          end
        end
        S_WAIT: begin
          if (cnt == 4'd0) state <= S_RESP;
          else             cnt   <= cnt - 4'd1;
        end
        S_RESP: begin
          state    <= S_IDLE;
          mem_busy <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
      if (resp_go_c) begin
        mem_ready <= 1'b1;
        mem_error <= err_c;
        if (!wr_c) mem_read_data <= err_c ? 32'd0 : load_c;
      end
    end
  end

  // Store commits on the edge ending RESP, so reset in RESP still aborts it.
  always_ff @(posedge clk) begin
    if (!rst && (state == S_RESP) && wr_q && !mem_error) begin
      for (int i = 0; i < 4; i++) begin
        if (be_c[i]) mem[idx_c][8*i +: 8] <= wlane_c[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem.sv
// Randomized self-checking bench for data_mem: one zero-wait and one 3-wait instance
// compared against a byte-level reference model.
module tb_data_mem;

  localparam int unsigned DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst   [2];
  logic [31:0] addr  [2];
  logic        rv    [2];
  logic        wv    [2];
  logic [2:0]  f3    [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];
  logic        ready [2];
  logic        err   [2];
  logic        busy  [2];

  always #5 clk = ~clk;

  data_mem #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(0)) u_w0 (
    .clk(clk), .rst(rst[0]), .mem_addr(addr[0]), .mem_read_valid(rv[0]),
    .mem_write_valid(wv[0]), .mem_funct3(f3[0]), .mem_write_data(wdata[0]),
    .mem_read_data(rdata[0]), .mem_ready(ready[0]), .mem_error(err[0]), .mem_busy(busy[0]));

  data_mem #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(3)) u_w3 (
    .clk(clk), .rst(rst[1]), .mem_addr(addr[1]), .mem_read_valid(rv[1]),
    .mem_write_valid(wv[1]), .mem_funct3(f3[1]), .mem_write_data(wdata[1]),
    .mem_read_data(rdata[1]), .mem_ready(ready[1]), .mem_error(err[1]), .mem_busy(busy[1]));

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] model [2][DEPTH];
  logic [31:0] last_rd [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: byte-addressed memory semantics from the RV32I access rules.
  task automatic ref_access(input int s, input logic wr, input logic [2:0] fn,
                            input logic [31:0] a, input logic [31:0] wd,
                            output logic e, output logic [31:0] r);
    longint      off;
    int unsigned size;
    int unsigned lane;
    logic [31:0] w;
    logic [31:0] v;
    off  = longint'(a) - longint'(BASE);
    lane = a % 4;
    case (fn)
      3'd0, 3'd4: size = 1;
      3'd1, 3'd5: size = 2;
      3'd2:       size = 4;
      default:    size = 0;
    endcase
    e = !(off >= 0 && off < longint'(DEPTH) * 4) || size == 0 ||
        (wr && fn >= 3'd4) || (a % size != 0);
    if (e) begin
      r = wr ? last_rd[s] : 32'd0;
      if (!wr) last_rd[s] = 32'd0;
    end else begin
      w = model[s][int'(off / 4)];
      if (wr) begin
        for (int b = 0; b < int'(size); b++) w[8*(int'(lane)+b) +: 8] = wd[8*b +: 8];
        model[s][int'(off / 4)] = w;
        r = last_rd[s];
      end else begin
        v = w >> (8 * lane);
        if (size == 1) begin
          v &= 32'hFF;
          if (fn == 3'd0 && v[7]) v |= 32'hFFFF_FF00;
        end else if (size == 2) begin
          v &= 32'hFFFF;
          if (fn == 3'd1 && v[15]) v |= 32'hFFFF_0000;
        end
        r = v;
        last_rd[s] = v;
      end
    end
  endtask

  task automatic do_access(input int s, input logic wr, input logic [2:0] fn,
                           input logic [31:0] a, input logic [31:0] wd,
                           output logic [31:0] rd_o, output logic er_o);
    logic        exp_e;
    logic [31:0] exp_r;
    int          lat;
    bit          got;
    ref_access(s, wr, fn, a, wd, exp_e, exp_r);
    addr[s]  = a;
    f3[s]    = fn;
    wdata[s] = wd;
    wv[s]    = wr;
    rv[s]    = wr ? 1'($urandom_range(0, 1)) : 1'b1;
    lat = 0;
    got = 0;
    rd_o = 32'd0;
    er_o = 1'b0;
    while (!got && lat < 40) begin
      @(negedge clk);
      lat++;
      if (ready[s]) begin
        got  = 1;
        rd_o = rdata[s];
        er_o = err[s];
        rv[s] = 1'b0;
        wv[s] = 1'b0;
      end else begin
        check("busy_wait", 32'(busy[s]), 32'd1);
        check("error_quiet", 32'(err[s]), 32'd0);
      end
    end
    rv[s] = 1'b0;
    wv[s] = 1'b0;
    if (!got) begin
      check("ready_timeout", 32'd0, 32'd1);
    end else begin
      check("latency", 32'(lat), (s == 0) ? 32'd1 : 32'd4);
      check("busy_at_ready", 32'(busy[s]), 32'd1);
      check("error", 32'(er_o), 32'(exp_e));
      check("read_data", rd_o, exp_r);
      @(negedge clk);
      check("ready_pulse", 32'(ready[s]), 32'd0);
      check("busy_clear", 32'(busy[s]), 32'd0);
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    logic        e1;
    logic [31:0] r1;
    logic [31:0] a;
    int          sel;

    for (int s = 0; s < 2; s++) begin
      rst[s] = 1'b1; rv[s] = 1'b0; wv[s] = 1'b0;
      addr[s] = 32'd0; f3[s] = 3'd0; wdata[s] = 32'd0;
      last_rd[s] = 32'd0;
      for (int i = 0; i < int'(DEPTH); i++) model[s][i] = 32'd0;
    end
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      check("rst_ready", 32'(ready[s]), 32'd0);
      check("rst_error", 32'(err[s]), 32'd0);
      check("rst_busy", 32'(busy[s]), 32'd0);
      check("rst_rdata", rdata[s], 32'd0);
      rst[s] = 1'b0;
    end
    @(negedge clk);

    // Known contents for every word that random stimulus can reach.
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 64; i++) do_access(s, 1'b1, 3'd2, BASE + 32'(4 * i), 32'd0, rd, er);
      for (int i = int'(DEPTH) - 2; i < int'(DEPTH); i++)
        do_access(s, 1'b1, 3'd2, BASE + 32'(4 * i), 32'd0, rd, er);
    end

    do_access(0, 1'b1, 3'd2, 32'h1004, 32'hDEAD_BEEF, rd, er);
    check("sw_error", 32'(er), 32'd0);
    do_access(0, 1'b0, 3'd2, 32'h1004, 32'd0, rd, er);
    check("lw_word", rd, 32'hDEAD_BEEF);
    do_access(0, 1'b0, 3'd0, 32'h1007, 32'd0, rd, er);
    check("lb_sign", rd, 32'hFFFF_FFDE);
    do_access(0, 1'b0, 3'd4, 32'h1007, 32'd0, rd, er);
    check("lbu_zero", rd, 32'h0000_00DE);
    do_access(0, 1'b0, 3'd1, 32'h1006, 32'd0, rd, er);
    check("lh_sign", rd, 32'hFFFF_DEAD);
    do_access(0, 1'b0, 3'd5, 32'h1004, 32'd0, rd, er);
    check("lhu_zero", rd, 32'h0000_BEEF);
    do_access(0, 1'b1, 3'd0, 32'h1005, 32'h0000_0055, rd, er);
    do_access(0, 1'b0, 3'd2, 32'h1004, 32'd0, rd, er);
    check("sb_merge", rd, 32'hDEAD_55EF);
    do_access(0, 1'b1, 3'd1, 32'h1006, 32'h0000_1234, rd, er);
    do_access(0, 1'b0, 3'd2, 32'h1004, 32'd0, rd, er);
    check("sh_merge", rd, 32'h1234_55EF);
    do_access(0, 1'b0, 3'd2, 32'h1002, 32'd0, rd, er);
    check("lw_misalign_err", 32'(er), 32'd1);
    check("lw_misalign_data", rd, 32'd0);
    do_access(0, 1'b1, 3'd1, 32'h1005, 32'h0000_FFFF, rd, er);
    check("sh_misalign_err", 32'(er), 32'd1);
    do_access(0, 1'b0, 3'd2, 32'h1004, 32'd0, rd, er);
    check("sh_misalign_nowrite", rd, 32'h1234_55EF);
    do_access(0, 1'b0, 3'd2, 32'h0FFC, 32'd0, rd, er);
    check("below_base_err", 32'(er), 32'd1);
    do_access(0, 1'b0, 3'd2, BASE + 32'(4 * DEPTH), 32'd0, rd, er);
    check("above_top_err", 32'(er), 32'd1);
    do_access(0, 1'b0, 3'd3, 32'h1004, 32'd0, rd, er);
    check("funct3_err", 32'(er), 32'd1);

    // Wait-state instance: a request presented while busy must be dropped.
    do_access(1, 1'b1, 3'd2, 32'h1004, 32'hDEAD_BEEF, rd, er);
    ref_access(1, 1'b0, 3'd2, 32'h1004, 32'd0, e1, r1);
    addr[1] = 32'h1004; f3[1] = 3'd2; rv[1] = 1'b1;
    @(negedge clk);
    check("w3_busy_n1", 32'(busy[1]), 32'd1);
    check("w3_ready_n1", 32'(ready[1]), 32'd0);
    rv[1] = 1'b0;
    addr[1] = 32'h1010; wdata[1] = 32'hCAFE_F00D; wv[1] = 1'b1;
    @(negedge clk);
    check("w3_busy_n2", 32'(busy[1]), 32'd1);
    check("w3_ready_n2", 32'(ready[1]), 32'd0);
    wv[1] = 1'b0;
    @(negedge clk);
    check("w3_busy_n3", 32'(busy[1]), 32'd1);
    check("w3_ready_n3", 32'(ready[1]), 32'd0);
    @(negedge clk);
    check("w3_ready_n4", 32'(ready[1]), 32'd1);
    check("w3_busy_n4", 32'(busy[1]), 32'd1);
    check("w3_rdata", rdata[1], r1);
    check("w3_rdata_const", rdata[1], 32'hDEAD_BEEF);
    @(negedge clk);
    check("w3_ready_n5", 32'(ready[1]), 32'd0);
    check("w3_busy_n5", 32'(busy[1]), 32'd0);
    do_access(1, 1'b0, 3'd2, 32'h1010, 32'd0, rd, er);
    check("ignored_store", rd, 32'd0);
    do_access(1, 1'b1, 3'd2, 32'h1010, 32'hCAFE_F00D, rd, er);
    do_access(1, 1'b0, 3'd2, 32'h1010, 32'd0, rd, er);
    check("represented_store", rd, 32'hCAFE_F00D);

    // Reset during WAIT aborts a pending store.
    do_access(1, 1'b1, 3'd2, 32'h1008, 32'h1111_2222, rd, er);
    addr[1] = 32'h1008; f3[1] = 3'd2; wdata[1] = 32'hA5A5_A5A5; wv[1] = 1'b1;
    @(negedge clk);
    wv[1] = 1'b0;
    @(negedge clk);
    rst[1] = 1'b1;
    @(negedge clk);
    rst[1] = 1'b0;
    check("abort_ready", 32'(ready[1]), 32'd0);
    check("abort_busy", 32'(busy[1]), 32'd0);
    check("abort_error", 32'(err[1]), 32'd0);
    check("abort_rdata", rdata[1], 32'd0);
    last_rd[1] = 32'd0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("abort_no_ready", 32'(ready[1]), 32'd0);
    end
    do_access(1, 1'b0, 3'd2, 32'h1008, 32'd0, rd, er);
    check("abort_prior_value", rd, 32'h1111_2222);

    for (int s = 0; s < 2; s++) begin
      for (int k = 0; k < 250; k++) begin
        sel = int'($urandom_range(0, 9));
        if (sel < 8)       a = BASE + 32'($urandom_range(0, 255));
        else if (sel == 8) a = BASE - 32'($urandom_range(1, 8));
        else               a = BASE + 32'(4 * DEPTH) - 32'd8 + 32'($urandom_range(0, 15));
        do_access(s, 1'($urandom_range(0, 9) < 4), 3'($urandom_range(0, 7)), a, $urandom, rd, er);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/data_mem.md
# data_mem

Data memory for the RV32I core, sitting directly downstream of the core's load/store port (`mem_addr`, `mem_read_valid`, `mem_write_valid`, `mem_write_data`, `mem_read_data`). It accepts one load or store at a time and performs RV32I byte, halfword and word access with sign or zero extension. It reports misaligned and out-of-range accesses, and inserts a configurable number of wait states so the core's stall path can be exercised.

## Interface
Parameters:
- `DEPTH_WORDS`, 1024: number of 32-bit words of storage.
- `BASE_ADDR`, 32'h0000_1000: byte address of word 0.
- `WAIT_STATES`, 0: extra cycles between request acceptance and response, range 0..15.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `mem_addr`  in  32  byte address of the access.
- `mem_read_valid`  in  1  load request.
- `mem_write_valid`  in  1  store request.
- `mem_funct3`  in  3  RV32I funct3 of the load or store (size/sign).
- `mem_write_data`  in  32  store data; the low bytes are used for SB/SH.
- `mem_read_data`  out  32  extended load result.
- `mem_ready`  out  1  one-cycle pulse: the access has completed.
- `mem_error`  out  1  valid with `mem_ready`: the access was misaligned, out of range, or had an illegal funct3.
- `mem_busy`  out  1  a request has been accepted and is not yet complete.

## Operation
- FSM has three states: IDLE, WAIT, RESP.
- **IDLE:**
  - If `mem_read_valid` or `mem_write_valid` is high, latch addr, funct3, write data and op.
  - Go to WAIT if `WAIT_STATES`>0, else go to RESP.
- **Read/write priority:** if both valids are high, the request is a store; the read is ignored.
- **WAIT:**
  - 4-bit counter loads `WAIT_STATES`-1 on entry and decrements each cycle.
  - At 0, go to RESP.
- **RESP:**
  - The access is performed, `mem_ready`=1 for one cycle, then return to IDLE.
  - A new request can be accepted on the cycle after RESP.
- **Requests while busy:** while `mem_busy`=1 (WAIT or RESP), request inputs are ignored. The core holds its request until `mem_ready`.
- **Offset:** off = addr − `BASE_ADDR` (32-bit).
  - In range iff addr ≥ `BASE_ADDR` and off < `DEPTH_WORDS`*4.
  - Word index = off[31:2]; lane = addr[1:0].
- **Legal loads:**
  - funct3 0 (LB) and 4 (LBU): any lane.
  - funct3 1 (LH) and 5 (LHU): lane[0]=0.
  - funct3 2 (LW): lane=0.
  - Any other funct3 is illegal.
- **Legal stores:**
  - funct3 0 (SB): any lane.
  - funct3 1 (SH): lane[0]=0.
  - funct3 2 (SW): lane=0.
  - Any other funct3 is illegal.
- **Load result:**
  - LB sign-extends byte[lane]; LBU zero-extends it.
  - LH sign-extends halfword[lane[1]]; LHU zero-extends it.
  - LW returns the whole word.
- **Store:** writes only the addressed bytes, taken from `mem_write_data`[7:0] (SB), [15:0] (SH) or all 32 bits (SW). The other bytes of the word are unchanged.
- **Error access** (misaligned, illegal funct3, or out of range):
  - No storage change.
  - `mem_error`=1 with `mem_ready`.
  - For a load, `mem_read_data` is set to 0.
- **`mem_read_data`:**
  - Updates only in RESP of a load.
  - Holds its value across stores and idle cycles.
- **Reset:**
  - State goes to IDLE; `mem_ready`, `mem_error` and `mem_busy` go to 0; `mem_read_data` goes to 0; counter goes to 0.
  - Storage contents are not cleared. Simulation initial value is 0.
  - Reset during WAIT or RESP aborts the access: a pending store is not written and no `mem_ready` is issued.

## Timing
- **Acceptance:** a request is sampled at rising edge N while in IDLE.
- **Latency:**
  - `WAIT_STATES`=0: `mem_ready` is high in cycle N+1, i.e. one-cycle latency, matching the registered fetch path.
  - `WAIT_STATES`=W: `mem_ready` is high in cycle N+1+W.
- **`mem_busy`:** high from cycle N+1 through the `mem_ready` cycle inclusive.
- **Qualified outputs:** `mem_read_data` and `mem_error` are valid in the `mem_ready` cycle. `mem_error` is 0 in all other cycles.
- **Store visibility:** the store write occurs at the edge ending the RESP cycle. A load accepted in the next cycle returns the new data.
- **Throughput:** at most one access per 2+W cycles.

## Test plan
- **Aligned word store/load, `WAIT_STATES`=0:**
  - SW 32'hDEADBEEF to 0x1004; LW 0x1004.
  - Required: `mem_ready` one cycle after each request; read data 32'hDEADBEEF; `mem_error`=0.
- **Byte/halfword extension:** after the SW above:
  - LB 0x1007 → 32'hFFFFFFDE.
  - LBU 0x1007 → 32'h000000DE.
  - LH 0x1006 → 32'hFFFFDEAD.
  - LHU 0x1004 → 32'h0000BEEF.
- **Partial stores:**
  - SB 8'h55 to 0x1005 → LW 0x1004 returns 32'hDEAD55EF.
  - SH 16'h1234 to 0x1006 → LW 0x1004 returns 32'h123455EF.
- **Errors:**
  - LW 0x1002 → `mem_error`=1, data 0.
  - SH 0x1005 → `mem_error`=1, memory unchanged.
  - LW 0x0FFC → `mem_error`=1.
  - LW `BASE_ADDR`+4*`DEPTH_WORDS` → `mem_error`=1.
  - LW with funct3=3 → `mem_error`=1.
- **`WAIT_STATES`=3:**
  - Issue a request at edge N → `mem_busy` high cycles N+1..N+4, `mem_ready` high at N+4 only.
  - A second request asserted during the busy cycles is ignored; it is accepted only once re-presented while in IDLE.
- **Reset mid-access:**
  - Issue SW 32'hA5A5A5A5 to 0x1008 with W=3; assert `rst` in cycle N+2.
  - Required: no `mem_ready`; all outputs 0; a subsequent LW 0x1008 returns its prior value.
